flick_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the bound flasher.
- Takes the raw, asynchronous, bouncy flick push-button and synchronises it to clk.
- Debounces it with a 4-state FSM and drives the flasher's flick input with a clean level, plus a one-cycle press pulse.
- Keeps press and glitch counters for bench and debug observability.

---
 rtl/flick_conditioner.sv | 132 +++++++++++++
 tb/tb_flick_conditioner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flick_conditioner.sv
// flick_conditioner
//   Conditions the raw flick push-button for the flasher: two-flop
//   synchroniser, then a four-state debounce FSM that issues a clean level
//   and a one-cycle press strobe. Press and glitch counters are exposed
//   for observability.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   btn_raw      in   raw button, asynchronous to clk, may bounce
//   flick        out  debounced button level
//   flick_pulse  out  one-cycle strobe per accepted press
//   press_count  out  accepted presses, wraps 255 -> 0
//   glitch_count out  rejected transitions, saturates at 255
module flick_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       flick,
  output logic       flick_pulse,
  output logic [7:0] press_count,
  output logic [7:0] glitch_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PRESS_CHK = 2'b01,
    HELD      = 2'b10,
    REL_CHK   = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flick_q, flick_d;
  logic             pulse_q, pulse_d;
  logic [7:0]       press_q, press_d;
  logic [7:0]       glitch_q, glitch_d;
  logic [7:0]       glitch_inc;

  assign btn_s = sync_q[1];

  // Saturating increment; the counter holds at 8'hFF.
  assign glitch_inc = (glitch_q == 8'hFF) ? glitch_q : glitch_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      flick_q  <= 1'b0;
      pulse_q  <= 1'b0;
      press_q  <= '0;
      glitch_q <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn_raw};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flick_q  <= flick_d;
      pulse_q  <= pulse_d;
      press_q  <= press_d;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flick_d  = flick_q;
    pulse_d  = 1'b0;
    press_d  = press_q;
    glitch_d = glitch_q;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_d  = IDLE;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          flick_d = 1'b1;
          pulse_d = 1'b1;
          press_d = press_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = REL_CHK;
          cnt_d   = '0;
        end
      end
      REL_CHK: begin
        if (btn_s) begin
          state_d  = HELD;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          flick_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign flick        = flick_q;
  assign flick_pulse  = pulse_q;
  assign press_count  = press_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_flick_conditioner.sv
// Bench for flick_conditioner: two instances (debounce 4 and 1) checked
// every cycle against a run-length model of the debounce rule, plus
// hand-computed literal checks from the test plan.
module tb_flick_conditioner;

  logic       clk;
  logic       rst;
  logic       btn_a, btn_b;
  logic       flick_a, pulse_a, flick_b, pulse_b;
  logic [7:0] press_a, glitch_a, press_b, glitch_b;

  flick_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(5)) u_dut_a (
    .clk(clk), .rst(rst), .btn_raw(btn_a),
    .flick(flick_a), .flick_pulse(pulse_a),
    .press_count(press_a), .glitch_count(glitch_a)
  );

  flick_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(5)) u_dut_b (
    .clk(clk), .rst(rst), .btn_raw(btn_b),
    .flick(flick_b), .flick_pulse(pulse_b),
    .press_count(press_b), .glitch_count(glitch_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          armed = 1'b0;

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the accepted level flips once the button, seen two edges late,
  // has disagreed with it for D+1 consecutive samples; a disagreeing run
  // that ends early counts as one glitch.
  typedef struct {
    logic        h0, h1;
    logic        level, pulse;
    int unsigned run;
    logic [7:0]  presses, glitches;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(input mdl_t m, input logic raw, input logic r,
                                input int unsigned d);
    logic seen;
    if (r) begin
      m.h0 = 1'b0; m.h1 = 1'b0; m.level = 1'b0; m.pulse = 1'b0;
      m.run = 0; m.presses = 8'h00; m.glitches = 8'h00;
      return m;
    end
    seen    = m.h1;
    m.h1    = m.h0;
    m.h0    = raw;
    m.pulse = 1'b0;
    if (seen != m.level) begin
      m.run++;
      if (m.run == d + 1) begin
        m.level = seen;
        m.run   = 0;
        if (seen) begin
          m.pulse   = 1'b1;
          m.presses = m.presses + 8'd1;
        end
      end
    end else begin
      if (m.run != 0 && m.glitches != 8'hFF) m.glitches = m.glitches + 8'd1;
      m.run = 0;
    end
    return m;
  endfunction

  always @(posedge clk) begin
    ma = step(ma, btn_a, rst, 4);
    mb = step(mb, btn_b, rst, 1);
    if (rst) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      cmp("a_flick",  {7'b0, flick_a}, {7'b0, ma.level});
      cmp("a_pulse",  {7'b0, pulse_a}, {7'b0, ma.pulse});
      cmp("a_press",  press_a,  ma.presses);
      cmp("a_glitch", glitch_a, ma.glitches);
      cmp("b_flick",  {7'b0, flick_b}, {7'b0, mb.level});
      cmp("b_pulse",  {7'b0, pulse_b}, {7'b0, mb.pulse});
      cmp("b_press",  press_b,  mb.presses);
      cmp("b_glitch", glitch_b, mb.glitches);
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input logic v);
    btn_a = v;
    btn_b = v;
  endtask

  int unsigned npulse;
  int unsigned rem_a, rem_b;

  initial begin
    rst = 1'b1;
    set_btn(1'b0);
    tick(2);

    // Clean press: A flick after edge 6, B (D=1) after edge 3.
    rst = 1'b0;
    set_btn(1'b1);
    for (int unsigned k = 0; k < 6; k++) begin
      tick(1);
      cmp("lit_clean_a_flick_low", {7'b0, flick_a}, 8'd0);
      if (k < 3) cmp("lit_d1_flick_low", {7'b0, flick_b}, 8'd0);
      if (k == 3) begin
        cmp("lit_d1_flick_e3", {7'b0, flick_b}, 8'd1);
        cmp("lit_d1_pulse_e3", {7'b0, pulse_b}, 8'd1);
      end
      if (k == 4) cmp("lit_d1_pulse_e4", {7'b0, pulse_b}, 8'd0);
    end
    tick(1);
    cmp("lit_clean_flick_e6", {7'b0, flick_a}, 8'd1);
    cmp("lit_clean_pulse_e6", {7'b0, pulse_a}, 8'd1);
    tick(1);
    cmp("lit_clean_pulse_e7", {7'b0, pulse_a}, 8'd0);
    cmp("lit_clean_press", press_a, 8'd1);
    cmp("lit_clean_glitch", glitch_a, 8'd0);
    cmp("lit_d1_press", press_b, 8'd1);

    // Release, then bounce on press.
    set_btn(1'b0);
    tick(10);
    cmp("lit_release_flick", {7'b0, flick_a}, 8'd0);
    set_btn(1'b1); tick(3);
    set_btn(1'b0); tick(1);
    set_btn(1'b1);
    npulse = 0;
    for (int unsigned k = 0; k < 12; k++) begin
      tick(1);
      if (k < 6) cmp("lit_bounce_flick_low", {7'b0, flick_a}, 8'd0);
      if (pulse_a) npulse++;
    end
    cmp("lit_bounce_glitch", glitch_a, 8'd1);
    cmp("lit_bounce_pulses", npulse[7:0], 8'd1);
    cmp("lit_bounce_flick", {7'b0, flick_a}, 8'd1);
    cmp("lit_bounce_press", press_a, 8'd2);

    // Release with bounce from HELD.
    npulse = 0;
    set_btn(1'b0); tick(1);
    cmp("lit_rel_hold0", {7'b0, flick_a}, 8'd1);
    tick(1);
    cmp("lit_rel_hold1", {7'b0, flick_a}, 8'd1);
    set_btn(1'b1); tick(1);
    cmp("lit_rel_hold2", {7'b0, flick_a}, 8'd1);
    set_btn(1'b0);
    for (int unsigned k = 0; k < 6; k++) begin
      tick(1);
      cmp("lit_rel_flick_high", {7'b0, flick_a}, 8'd1);
      if (pulse_a) npulse++;
    end
    tick(1);
    cmp("lit_rel_flick_e6", {7'b0, flick_a}, 8'd0);
    if (pulse_a) npulse++;
    cmp("lit_rel_no_pulse", npulse[7:0], 8'd0);
    cmp("lit_rel_glitch", glitch_a, 8'd2);

    // Reset in PRESS_CHK with cnt=2.
    tick(2);
    set_btn(1'b1);
    tick(5);
    rst = 1'b1;
    tick(1);
    cmp("lit_rst_flick",  {7'b0, flick_a}, 8'd0);
    cmp("lit_rst_pulse",  {7'b0, pulse_a}, 8'd0);
    cmp("lit_rst_press",  press_a, 8'd0);
    cmp("lit_rst_glitch", glitch_a, 8'd0);
    rst = 1'b0;
    for (int unsigned k = 0; k < 6; k++) begin
      tick(1);
      cmp("lit_rst_requal_low", {7'b0, flick_a}, 8'd0);
      cmp("lit_rst_no_pulse",  {7'b0, pulse_a}, 8'd0);
    end
    tick(1);
    cmp("lit_rst_requal_flick", {7'b0, flick_a}, 8'd1);
    cmp("lit_rst_requal_pulse", {7'b0, pulse_a}, 8'd1);

    // press_count wrap.
    set_btn(1'b0);
    tick(10);
    rst = 1'b1; tick(2); rst = 1'b0;
    for (int unsigned i = 0; i < 256; i++) begin
      set_btn(1'b1); tick(8);
      set_btn(1'b0); tick(8);
      if (i == 254) cmp("lit_press_ff", press_a, 8'hFF);
    end
    cmp("lit_press_wrap", press_a, 8'h00);
    cmp("lit_press_wrap_glitch", glitch_a, 8'h00);

    // glitch_count saturation.
    for (int unsigned i = 0; i < 300; i++) begin
      set_btn(1'b1); tick(1);
      set_btn(1'b0); tick(3);
    end
    cmp("lit_glitch_sat", glitch_a, 8'hFF);
    cmp("lit_glitch_sat_press", press_a, 8'h00);
    cmp("lit_glitch_sat_flick", {7'b0, flick_a}, 8'd0);

    // Randomised runs with occasional reset.
    rem_a = 0;
    rem_b = 0;
    for (int unsigned c = 0; c < 3000; c++) begin
      if (rem_a == 0) begin
        btn_a = ~btn_a;
        rem_a = $urandom_range(1, 10);
      end
      if (rem_b == 0) begin
        btn_b = ~btn_b;
        rem_b = $urandom_range(1, 4);
      end
      rst = ($urandom_range(0, 199) == 0);
      tick(1);
      rem_a--;
      rem_b--;
    end
    rst = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
